addsub_seq: RTL and testbench

- Parametrised, multi-cycle adder-subtractor for the ALU datapath; successor to the fixed 16-bit ripple add/sub chain.
- Processes CHUNK bits per clock, LSB chunk first, through a registered carry. Area scales with CHUNK; latency scales with WIDTH/CHUNK.
- Adds a valid/ready handshake, status flags (carry, signed overflow, zero, negative) and an optional signed-saturation mode.

---
 rtl/addsub_seq_if.sv | 28 ++
 rtl/addsub_seq.sv | 132 +++++++++++++
 tb/tb_addsub_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// rtl/addsub_seq_if.sv - request/result handshake bundle for the chunked adder-subtractor
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle add/sub, CHUNK bits per clock LSB first, with flags and saturation
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst,
  addsub_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic             sat_q,    sat_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;
  logic             neg_q,    neg_d;

  int               base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   csum;
  logic             msb_cin;
  logic             ovf_now;
  logic             last;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sat_d    = sat_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;

    base    = 32'(cnt_q) * CHUNK;
    a_ch    = opa_q[base +: CHUNK];
    b_ch    = opb_q[base +: CHUNK];
    csum    = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last chunk.
    msb_cin = opa_q[WIDTH-1] ^ opb_q[WIDTH-1] ^ csum[CHUNK-1];
    ovf_now = msb_cin ^ csum[CHUNK];
    last    = (cnt_q == CW'(N - 1));

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.a;
          opb_d   = bus.b ^ {WIDTH{bus.sub}};
          sat_d   = bus.sat;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        result_d[base +: CHUNK] = csum[CHUNK-1:0];
        carry_d = csum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cout_d = csum[CHUNK];
          ovf_d  = ovf_now;
          if (sat_q && ovf_now) begin
            result_d = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
          end
          zero_d  = (result_d == '0);
          neg_d   = result_d[WIDTH-1];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  // in_ready is gated by rst so it reads 0 while reset is held, even though state is IDLE.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - scoreboard bench for addsub_seq (16/4 and 8/1 instances)
module tb_addsub_seq;
  typedef struct {
    logic [15:0] result;
    bit          cout;
    bit          ovf;
    bit          zero;
    bit          neg;
    longint      acc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  exp_t   ea, eb;
  bit     pva = 1'b0;
  bit     pvb = 1'b0;

  addsub_seq_if #(.WIDTH(16)) ifa ();
  addsub_seq_if #(.WIDTH(8))  ifb ();

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  addsub_seq #(.WIDTH(8),  .CHUNK(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: unsigned sum for carry, true signed sum for overflow, then saturate by sign of A.
  function automatic exp_t model(input int w, input logic [15:0] a, b, input bit s, st);
    exp_t   e;
    longint one  = 1;
    longint mask = (one << w) - 1;
    longint ua   = longint'(a) & mask;
    longint ub   = longint'(b) & mask;
    longint sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    longint sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    longint full = s ? ua + ((~ub) & mask) + 1 : ua + ub;
    longint sres = s ? sa - sb : sa + sb;
    longint res;
    e.cout = ((full >> w) & 1) != 0;
    e.ovf  = (sres > (one << (w - 1)) - 1) || (sres < -(one << (w - 1)));
    res    = full & mask;
    if (st && e.ovf) res = (sa < 0) ? (one << (w - 1)) : (one << (w - 1)) - 1;
    e.result = 16'(res);
    e.zero   = (res == 0);
    e.neg    = ((res >> (w - 1)) & 1) != 0;
    e.acc    = 0;
    return e;
  endfunction

  function automatic bit rdy(input bit w);
    return w ? ifb.in_ready : ifa.in_ready;
  endfunction

  function automatic bit vld(input bit w);
    return w ? ifb.out_valid : ifa.out_valid;
  endfunction

  task automatic drive(input bit w, input bit v, input logic [15:0] a, b, input bit s, st);
    if (w) begin
      ifb.in_valid = v; ifb.a = a[7:0]; ifb.b = b[7:0]; ifb.sub = s; ifb.sat = st;
    end else begin
      ifa.in_valid = v; ifa.a = a; ifa.b = b; ifa.sub = s; ifa.sat = st;
    end
  endtask

  task automatic set_ordy(input bit w, input bit v);
    if (w) ifb.out_ready = v;
    else   ifa.out_ready = v;
  endtask

  task automatic op(input bit w, input logic [15:0] a, b, input bit s, st, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!rdy(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    e     = model(w ? 8 : 16, a, b, s, st);
    e.acc = cyc + 1;
    if (w) qb.push_back(e);
    else   qa.push_back(e);
    drive(w, 1'b1, a, b, s, st);
    @(negedge clk);
    // Stray request and operand churn while busy must not disturb the operation in flight.
    drive(w, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    n = 0;
    while (!vld(w) && n < 50) begin
      @(negedge clk);
      drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      n++;
    end
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    chk("done_wait", 64'(n < 50), 64'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1 set_ordy(w, 1'b1);
    @(posedge clk);
    #1 set_ordy(w, 1'b0);
    @(negedge clk);
    chk("in_ready_after_hs", 64'(rdy(w)), 64'd1);
    chk("out_valid_after_hs", 64'(vld(w)), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.out_valid) begin
        chk("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          ea = qa[0];
          if (!pva) chk("a_latency", 64'(cyc - ea.acc), 64'd4);
          chk("a_result", 64'(ifa.result), 64'(ea.result));
          chk("a_cout", 64'(ifa.cout), 64'(ea.cout));
          chk("a_ovf", 64'(ifa.ovf), 64'(ea.ovf));
          chk("a_zero", 64'(ifa.zero), 64'(ea.zero));
          chk("a_neg", 64'(ifa.neg), 64'(ea.neg));
          chk("a_in_ready_done", 64'(ifa.in_ready), 64'd0);
          if (ifa.out_ready) void'(qa.pop_front());
        end
      end
      if (ifb.out_valid) begin
        chk("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          eb = qb[0];
          if (!pvb) chk("b_latency", 64'(cyc - eb.acc), 64'd8);
          chk("b_result", 64'(ifb.result), 64'(eb.result[7:0]));
          chk("b_cout", 64'(ifb.cout), 64'(eb.cout));
          chk("b_ovf", 64'(ifb.ovf), 64'(eb.ovf));
          chk("b_zero", 64'(ifb.zero), 64'(eb.zero));
          chk("b_neg", 64'(ifb.neg), 64'(eb.neg));
          chk("b_in_ready_done", 64'(ifb.in_ready), 64'd0);
          if (ifb.out_ready) void'(qb.pop_front());
        end
      end
      pva = ifa.out_valid;
      pvb = ifb.out_valid;
    end else begin
      pva = 1'b0;
      pvb = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_result", 64'({ifa.result, ifa.cout, ifa.ovf, ifa.zero, ifa.neg}), 64'd0);
    chk("rst_b_state", 64'({ifb.in_ready, ifb.out_valid, ifb.result}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(ifa.in_ready), 64'd1);

    op(1'b0, 16'h1234, 16'h0FF1, 1'b0, 1'b0, 0);
    op(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b0, 0);
    op(1'b0, 16'h1234, 16'h1234, 1'b1, 1'b0, 0);
    op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 3);
    op(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b1, 0);
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);

    // Abort an operation in its second busy cycle; no result may ever be presented for it.
    drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({ifa.in_ready, ifa.out_valid, ifa.result, ifa.cout, ifa.ovf, ifa.zero, ifa.neg}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(ifa.in_ready), 64'd1);
    op(1'b0, 16'h0100, 16'h0200, 1'b0, 1'b0, 0);

    repeat (30) op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    op(1'b1, 16'h007F, 16'h0001, 1'b0, 1'b0, 0);
    op(1'b1, 16'h007F, 16'h0001, 1'b0, 1'b1, 1);
    op(1'b1, 16'h0080, 16'h0001, 1'b1, 1'b0, 0);
    repeat (15) op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    repeat (3) @(negedge clk);
    chk("a_sb_drained", 64'(qa.size()), 64'd0);
    chk("b_sb_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
